dmem_arb: RTL and testbench
===========================

# dmem_arb

Arbiter and sequencer for the dual-bank data memory pair (two 64-bit × 256-entry banks, byte write enables, shared active-low chip select, independent low/high bank addresses). It shares the memory between the vector/scalar unit port (vu_) and the DMA engine port (dma_). It also splits each 128-bit byte-addressed access across the two banks and returns read data tagged to the issuing requester. It sits between the requesters and the df_* inputs of the memory pair.

## Interface
- STARVE_MAX, 8: consecutive cycles a requesting DMA may lose to VU before DMA is forced to win (1..15).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- vu_req  in  1  VU access request; held until vu_gnt.
- vu_we  in  1  1 = write, 0 = read.
- vu_addr  in  12  byte address; bits [3:0] select start byte in the 16-byte line.
- vu_wmask  in  16  byte write mask, lane-aligned (bit i = byte lane i; lanes 0-7 low bank, 8-15 high bank).
- vu_wdata  in  128  lane-aligned write data.
- vu_gnt  out  1  request accepted this cycle.
- vu_rvalid  out  1  vu read data valid on rdata.
- dma_req, dma_we, dma_addr[11:0], dma_wmask[15:0], dma_wdata[127:0]  in  as vu_*; dma_addr[3:0] must be 0.
- dma_last  in  1  qualifies dma_req: final beat of a DMA burst.
- dma_gnt  out  1  request accepted this cycle.
- dma_rvalid  out  1  dma read data valid on rdata.
- rdata  out  128  passthrough of dmem_dataout.
- df_chip_sel_l  out  1  memory chip select, active low.
- df_wen_l  out  16  per-byte write enable, active low.
- df_addr_low  out  8  low bank line address.
- df_addr_high  out  8  high bank line address.
- df_datain  out  128  write data.
- dmem_dataout  in  128  memory read data.

## Operation
- States: ARB, DMA_LOCK.
- ARB:
  - Only one requester asserting: that requester wins.
  - Both asserting: VU wins unless starve_cnt == STARVE_MAX, in which case DMA wins.
  - A DMA grant with dma_last=0 moves the FSM to DMA_LOCK.
- DMA_LOCK:
  - Only DMA can be granted; vu_gnt is held 0.
  - The FSM returns to ARB in the cycle after the grant of a beat with dma_last=1.
  - A lock cycle with no dma_req issues nothing and stays locked.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, in every ARB cycle with dma_req=1 and vu_gnt=1.
  - Clears on any dma_gnt.
  - Holds otherwise.
- Bank split on the winner's address A:
  - df_addr_high = A[11:4].
  - df_addr_low = A[11:4] + A[3], mod 256 (line 0xFF wraps to 0x00).
- Write: df_wen_l = ~wmask.
- Read: df_wen_l = 16'hFFFF.
- Idle cycle (no grant):
  - df_chip_sel_l = 1 and df_wen_l = 16'hFFFF.
  - df_addr_low, df_addr_high and df_datain hold their previous values.
- Read return: a 2-entry owner pipeline records {valid, is_dma} for each granted read. Writes occupy a pipeline slot with valid=0.
- vu_gnt and dma_gnt are never both 1.

## Timing
- Grant in cycle N (combinational from the req inputs and registered state).
- df_* outputs are registered and drive the memory in cycle N+1.
- Memory data is valid in cycle N+2. The matching rvalid is 1 in N+2; rdata = dmem_dataout.
- Back-to-back grants are allowed every cycle; throughput is 1 access/cycle.
- Reset (synchronous; also mid-burst or mid-pipeline):
  - FSM goes to ARB and starve_cnt to 0.
  - df_chip_sel_l = 1, df_wen_l = 16'hFFFF, df_addr_low = df_addr_high = 0, df_datain = 0.
  - vu_gnt = dma_gnt = 0 while reset is high.
  - vu_rvalid = dma_rvalid = 0, and in-flight reads are dropped.
- Reads return in grant order, including when ownership alternates cycle by cycle.

## Test plan
- VU read of addr 0x0A8 alone -> vu_gnt N; at N+1 df_addr_high=0x0A, df_addr_low=0x0B, df_chip_sel_l=0, df_wen_l=FFFF; vu_rvalid at N+2 only.
- Both requesting continuously with STARVE_MAX=8, DMA with dma_last=1 each beat -> pattern of 8 VU grants, then 1 DMA grant, repeating; starve_cnt never exceeds 8.
- DMA 4-beat burst (dma_last on beat 4) while VU requests -> 4 consecutive dma_gnt, vu_gnt=0 throughout, VU granted in the cycle after beat 4.
- VU write at addr 0xFF8 with wmask 0xFF00 -> df_addr_high=0xFF, df_addr_low=0x00, df_wen_l=0x00FF, no rvalid.
- Alternating VU read / DMA read every cycle -> vu_rvalid and dma_rvalid alternate 2 cycles later, never both high.
- Reset asserted one cycle after a DMA read grant, mid-burst -> no dma_rvalid, FSM back in ARB, df_chip_sel_l=1; a VU request after reset releases is granted immediately.

Source files
------------

// File: rtl/dmem_arb.sv
// dmem_arb: VU/DMA arbiter and 128-bit bank-split sequencer
// for the dual-bank data memory pair.
module dmem_arb #(
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vu_req,
  input  logic         vu_we,
  input  logic [11:0]  vu_addr,
  input  logic [15:0]  vu_wmask,
  input  logic [127:0] vu_wdata,
  output logic         vu_gnt,
  output logic         vu_rvalid,
  input  logic         dma_req,
  input  logic         dma_we,
  input  logic [11:0]  dma_addr,
  input  logic [15:0]  dma_wmask,
  input  logic [127:0] dma_wdata,
  input  logic         dma_last,
  output logic         dma_gnt,
  output logic         dma_rvalid,
  output logic [127:0] rdata,
  output logic         df_chip_sel_l,
  output logic [15:0]  df_wen_l,
  output logic [7:0]   df_addr_low,
  output logic [7:0]   df_addr_high,
  output logic [127:0] df_datain,
  input  logic [127:0] dmem_dataout
);

  typedef enum logic {ARB, DMA_LOCK} state_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e       state_q, state_d;
  logic [3:0]   starve_q, starve_d;
  logic         cs_q, cs_d;
  logic [15:0]  wen_q, wen_d;
  logic [7:0]   alo_q, alo_d;
  logic [7:0]   ahi_q, ahi_d;
  logic [127:0] din_q, din_d;
  logic [1:0]   p1_q, p1_d;
  logic [1:0]   p2_q, p2_d;

  logic         vg, dg;
  logic [11:0]  a;
  logic         we;
  logic [15:0]  m;
  logic [127:0] wd;
  logic         unused_addr;

  assign unused_addr = ^{vu_addr[2:0], dma_addr[2:0]};

  always_comb begin
    vg       = 1'b0;
    dg       = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    if (!reset) begin
      unique case (state_q)
        ARB: begin
          if (dma_req && (!vu_req || starve_q == SMAX))
            dg = 1'b1;
          else
            vg = vu_req;
        end
        DMA_LOCK: dg = dma_req;
        default: ;
      endcase
    end
    if (dg) begin
      starve_d = '0;
      state_d  = dma_last ? ARB : DMA_LOCK;
    end else if (vg && dma_req && starve_q != SMAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    a     = vg ? vu_addr  : dma_addr;
    we    = vg ? vu_we    : dma_we;
    m     = vg ? vu_wmask : dma_wmask;
    wd    = vg ? vu_wdata : dma_wdata;
    cs_d  = 1'b1;
    wen_d = '1;
    alo_d = alo_q;
    ahi_d = ahi_q;
    din_d = din_q;
    p1_d  = 2'b00;
    if (vg || dg) begin
      cs_d  = 1'b0;
      wen_d = we ? ~m : '1;
      ahi_d = a[11:4];
      // odd start half-line: low bank begins on the next line
      alo_d = a[11:4] + {7'd0, a[3]};
      din_d = wd;
      p1_d  = {~we, dg};
    end
    p2_d = p1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB;
      starve_q <= '0;
      cs_q     <= 1'b1;
      wen_q    <= '1;
      alo_q    <= '0;
      ahi_q    <= '0;
      din_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cs_q     <= cs_d;
      wen_q    <= wen_d;
      alo_q    <= alo_d;
      ahi_q    <= ahi_d;
      din_q    <= din_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  assign vu_gnt        = vg;
  assign dma_gnt       = dg;
  assign vu_rvalid     = p2_q[1] & ~p2_q[0] & ~reset;
  assign dma_rvalid    = p2_q[1] &  p2_q[0] & ~reset;
  assign rdata         = dmem_dataout;
  assign df_chip_sel_l = cs_q;
  assign df_wen_l      = wen_q;
  assign df_addr_low   = alo_q;
  assign df_addr_high  = ahi_q;
  assign df_datain     = din_q;

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed + random stimulus against a
// cycle-history reference model of the arbiter.
module tb_dmem_arb;
  localparam int SM = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         vu_req, vu_we, vu_gnt, vu_rvalid;
  logic [11:0]  vu_addr;
  logic [15:0]  vu_wmask;
  logic [127:0] vu_wdata;
  logic         dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
  logic [11:0]  dma_addr;
  logic [15:0]  dma_wmask;
  logic [127:0] dma_wdata;
  logic [127:0] rdata, dmem_dataout;
  logic         df_chip_sel_l;
  logic [15:0]  df_wen_l;
  logic [7:0]   df_addr_low, df_addr_high;
  logic [127:0] df_datain;

  dmem_arb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .vu_req(vu_req), .vu_we(vu_we), .vu_addr(vu_addr),
    .vu_wmask(vu_wmask), .vu_wdata(vu_wdata),
    .vu_gnt(vu_gnt), .vu_rvalid(vu_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wmask(dma_wmask), .dma_wdata(dma_wdata),
    .dma_last(dma_last), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .rdata(rdata),
    .df_chip_sel_l(df_chip_sel_l), .df_wen_l(df_wen_l),
    .df_addr_low(df_addr_low), .df_addr_high(df_addr_high),
    .df_datain(df_datain), .dmem_dataout(dmem_dataout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit done = 1'b0;

  bit           m_lock;
  int           m_starve;
  logic         m_cs;
  logic [15:0]  m_wen;
  logic [7:0]   m_lo, m_hi;
  logic [127:0] m_din;
  int           hist [0:8191];

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input bit rst, input bit vr, input bit vw,
                      input logic [11:0] va, input logic [15:0] vm,
                      input bit dr, input bit dw, input bit dl,
                      input logic [11:0] da, input logic [15:0] dm);
    bit eg_v, eg_d, w;
    logic [11:0]  a;
    logic [15:0]  msk;
    logic [127:0] md, d;
    int k2;
    @(negedge clk);
    reset = rst; vu_req = vr; vu_we = vw; vu_addr = va;
    vu_wmask = vm; vu_wdata = rnd128();
    dma_req = dr; dma_we = dw; dma_last = dl;
    dma_addr = da; dma_wmask = dm; dma_wdata = rnd128();
    md = rnd128(); dmem_dataout = md;
    eg_v = 1'b0; eg_d = 1'b0;
    if (!rst) begin
      if (m_lock) eg_d = dr;
      else if (vr && dr) begin
        if (m_starve == SM) eg_d = 1'b1; else eg_v = 1'b1;
      end else begin
        eg_v = vr; eg_d = dr;
      end
    end
    k2 = (cyc >= 2) ? hist[cyc-2] : 0;
    #2;
    n_chk++;
    if (vu_gnt !== eg_v)
      $error("FAIL vu_gnt obs=%0h exp=%0h", vu_gnt, eg_v);
    else n_pass++;
    n_chk++;
    if (dma_gnt !== eg_d)
      $error("FAIL dma_gnt obs=%0h exp=%0h", dma_gnt, eg_d);
    else n_pass++;
    n_chk++;
    if ((vu_gnt & dma_gnt) !== 1'b0)
      $error("FAIL gnt_excl");
    else n_pass++;
    n_chk++;
    if (rdata !== md)
      $error("FAIL rdata obs=%0h exp=%0h", rdata, md);
    else n_pass++;
    n_chk++;
    if (vu_rvalid !== (!rst && k2 == 1))
      $error("FAIL vu_rvalid obs=%0h", vu_rvalid);
    else n_pass++;
    n_chk++;
    if (dma_rvalid !== (!rst && k2 == 2))
      $error("FAIL dma_rvalid obs=%0h", dma_rvalid);
    else n_pass++;
    if (!rst) begin
      n_chk++;
      if (df_chip_sel_l !== m_cs)
        $error("FAIL cs_l obs=%0h exp=%0h", df_chip_sel_l, m_cs);
      else n_pass++;
      n_chk++;
      if (df_wen_l !== m_wen)
        $error("FAIL wen_l obs=%0h exp=%0h", df_wen_l, m_wen);
      else n_pass++;
      n_chk++;
      if (df_addr_low !== m_lo)
        $error("FAIL addr_lo obs=%0h exp=%0h", df_addr_low, m_lo);
      else n_pass++;
      n_chk++;
      if (df_addr_high !== m_hi)
        $error("FAIL addr_hi obs=%0h exp=%0h", df_addr_high, m_hi);
      else n_pass++;
      n_chk++;
      if (df_datain !== m_din)
        $error("FAIL datain obs=%0h exp=%0h", df_datain, m_din);
      else n_pass++;
    end
    hist[cyc] = eg_v ? (vw ? 3 : 1) : eg_d ? (dw ? 3 : 2) : 0;
    if (rst) begin
      m_lock = 1'b0; m_starve = 0; m_cs = 1'b1; m_wen = '1;
      m_lo = '0; m_hi = '0; m_din = '0;
      hist[cyc] = 0;
      if (cyc >= 1) hist[cyc-1] = 0;
    end else begin
      if (eg_d) m_starve = 0;
      else if (!m_lock && dr && eg_v && m_starve < SM) m_starve++;
      if (eg_d) m_lock = !dl;
      if (eg_v || eg_d) begin
        a   = eg_v ? va : da;
        msk = eg_v ? vm : dm;
        w   = eg_v ? vw : dw;
        d   = eg_v ? vu_wdata : dma_wdata;
        m_cs  = 1'b0;
        m_wen = w ? ~msk : 16'hFFFF;
        m_hi  = a[11:4];
        m_lo  = 8'((a >> 4) + ((a >> 3) & 12'd1));
        m_din = d;
      end else begin
        m_cs = 1'b1; m_wen = 16'hFFFF;
      end
    end
    n_chk++;
    if (m_starve > SM)
      $error("FAIL starve_bound %0d", m_starve);
    else n_pass++;
    cyc++;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      tick(0, 0, 0, 12'h0, 16'h0, 0, 0, 1, 12'h0, 16'h0);
  endtask

  initial begin
    #200000;
    if (!done) begin
      n_chk++;
      $error("FAIL timeout: stimulus did not complete");
      $finish;
    end
  end

  initial begin
    logic [11:0] ra, rda;
    reset = 1'b1; vu_req = 0; vu_we = 0; vu_addr = 0;
    vu_wmask = 0; vu_wdata = 0; dma_req = 0; dma_we = 0;
    dma_last = 0; dma_addr = 0; dma_wmask = 0; dma_wdata = 0;
    dmem_dataout = 0;
    for (int i = 0; i < 8192; i++) hist[i] = 0;
    m_lock = 0; m_starve = 0; m_cs = 1; m_wen = '1;
    m_lo = 0; m_hi = 0; m_din = 0;

    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (df_chip_sel_l !== 1'b1 || df_wen_l !== 16'hFFFF ||
        df_addr_low !== 8'h00 || df_addr_high !== 8'h00 ||
        df_datain !== '0 || vu_rvalid !== 1'b0 ||
        dma_rvalid !== 1'b0)
      $error("FAIL reset state cs=%0h wen=%0h lo=%0h hi=%0h",
             df_chip_sel_l, df_wen_l, df_addr_low, df_addr_high);
    else
      n_pass++;
    idle(1);

    tick(0, 1, 0, 12'h0A8, 16'h0, 0, 0, 1, 12'h0, 16'h0);
    idle(3);

    for (int i = 0; i < 27; i++)
      tick(0, 1, 0, 12'($urandom), 16'h0,
           1, 0, 1, {8'($urandom), 4'h0}, 16'h0);
    idle(2);

    tick(0, 0, 0, 12'h100, 16'h0, 1, 0, 0, 12'h200, 16'h0);
    for (int i = 1; i < 4; i++)
      tick(0, 1, 0, 12'h100, 16'h0, 1, 0, (i == 3),
           12'(12'h200 + 16 * i), 16'h0);
    tick(0, 1, 0, 12'h100, 16'h0, 0, 0, 1, 12'h0, 16'h0);
    idle(3);

    tick(0, 1, 1, 12'hFF8, 16'hFF00, 0, 0, 1, 12'h0, 16'h0);
    idle(3);

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        tick(0, 1, 0, 12'(i * 24), 16'h0, 0, 0, 1, 12'h0, 16'h0);
      else
        tick(0, 0, 0, 12'h0, 16'h0, 1, 0, 1, 12'(i * 32), 16'h0);
    end
    idle(3);

    tick(0, 0, 0, 12'h0, 16'h0, 1, 0, 0, 12'h340, 16'h0);
    tick(1, 1, 0, 12'h010, 16'h0, 1, 0, 0, 12'h350, 16'h0);
    tick(0, 1, 0, 12'h018, 16'h0, 1, 0, 0, 12'h350, 16'h0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      ra  = 12'($urandom);
      rda = {8'($urandom), 4'h0};
      tick(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 9) < 6), $urandom_range(0, 1),
           ra, 16'($urandom),
           ($urandom_range(0, 9) < 5), $urandom_range(0, 1),
           ($urandom_range(0, 9) < 4), rda, 16'($urandom));
    end
    idle(3);

    done = 1'b1;
    if (n_pass != n_chk)
      $error("FAIL %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
